// File: rtl/rotate_ctrl_gen.sv
// ============================================================================
// rotate_ctrl_gen : rotate-stage controller, OUTER_CNT read passes of
//                   INNER_CNT write/update steps each, with handshakes/abort.
// Revision        : 1.0  initial release
// ============================================================================
`default_nettype none

module rotate_ctrl_gen #(
  parameter int INNER_CNT = 24,
  parameter int OUTER_CNT = 64,
  parameter int IW        = (INNER_CNT > 1) ? $clog2(INNER_CNT) : 1,
  parameter int OW        = (OUTER_CNT > 1) ? $clog2(OUTER_CNT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          rd_valid,
  input  logic          flush_ack,
  output logic          read_en,
  output logic          wr_en_1,
  output logic          wr_en_2,
  output logic          file_write,
  output logic          done,
  output logic          busy,
  output logic [IW-1:0] inner_idx,
  output logic [OW-1:0] outer_idx
);

  localparam logic [IW-1:0] c_INNER_LAST = IW'(INNER_CNT - 1);
  localparam logic [OW-1:0] c_OUTER_LAST = OW'(OUTER_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_WAIT_RD  = 3'd2,
    S_WRITE    = 3'd3,
    S_INNER_UP = 3'd4,
    S_OUTER_UP = 3'd5,
    S_FLUSH    = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_inner;
  logic [IW-1:0] w_inner_nxt;
  logic [OW-1:0] r_outer;
  logic [OW-1:0] w_outer_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_inner <= '0;
      r_outer <= '0;
    end else begin
      r_state <= w_next;
      r_inner <= w_inner_nxt;
      r_outer <= w_outer_nxt;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_inner_nxt = r_inner;
    w_outer_nxt = r_outer;
    read_en     = 1'b0;
    wr_en_1     = 1'b0;
    wr_en_2     = 1'b0;
    file_write  = 1'b0;
    done        = 1'b0;
    busy        = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        w_inner_nxt = '0;
        w_outer_nxt = '0;
        if (start && !abort) w_next = S_READ;
      end
      S_READ: begin
        read_en = 1'b1;
        w_next  = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (rd_valid) w_next = S_WRITE;
      end
      S_WRITE: begin
        wr_en_1 = 1'b1;
        w_next  = S_INNER_UP;
      end
      S_INNER_UP: begin
        wr_en_2 = 1'b1;
        if (r_inner == c_INNER_LAST) begin
          w_inner_nxt = '0;
          w_next      = S_OUTER_UP;
        end else begin
          w_inner_nxt = r_inner + IW'(1);
          w_next      = S_WRITE;
        end
      end
      S_OUTER_UP: begin
        if (r_outer == c_OUTER_LAST) begin
          w_outer_nxt = '0;
          w_next      = S_FLUSH;
        end else begin
          w_outer_nxt = r_outer + OW'(1);
          w_next      = S_READ;
        end
      end
      S_FLUSH: begin
        file_write = 1'b1;
        if (flush_ack) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    // Abort overrides every transition above, including DONE -> IDLE.
    if (abort && (r_state != S_IDLE)) begin
      w_next      = S_IDLE;
      w_inner_nxt = '0;
      w_outer_nxt = '0;
    end
  end

  assign inner_idx = r_inner;
  assign outer_idx = r_outer;

endmodule

`default_nettype wire
